enemy_tank_ctrl: RTL
====================

# enemy_tank_ctrl

Autonomous driver for one enemy tank. Sits directly upstream of a tank instance and drives its `move_up/down/left/right` and `fire` inputs in place of keyboard decode. It consumes the tank's `blocked`, `got_hit`, position, direction and `bullet_active` outputs, plus the player tank position. It produces registered, one-hot movement commands, advanced once per `frame_clk`, from a per-instance LFSR, run/pause timers and a line-of-sight fire rule.

## Interface
- `LFSR_SEED`, 16'hACE1: nonzero per-instance seed.
- `DIR_SPAWN`, 4'b0010: direction register value after reset or respawn.
- `SPAWN_WAIT_FRAMES`, 60: idle frames after reset or hit; range 1..255.
- `MIN_RUN`, 16: minimum cruise length in frames.
- `PAUSE_FRAMES`, 8: length of a voluntary stop.
- `FIRE_COOLDOWN`, 45: frames between fire pulses; range 1..127.
- `ALIGN_TOL`, 8: pixel tolerance for line-of-sight.
- `frame_clk` in 1: the only clock; one edge per video frame.
- `Reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: low while the tank is dead or the game is paused.
- `blocked` in 1: from the tank; a brick or boundary stops the current move.
- `got_hit` in 1: from the tank; the tank is respawning this frame.
- `tank_x`, `tank_y` in 10: this tank's top-left corner.
- `tank_dir` in 4: this tank's one-hot facing direction.
- `player_x`, `player_y` in 10: the player tank's top-left corner.
- `bullet_active` in 1: this tank's own bullet is in flight.
- `move_up`, `move_down`, `move_left`, `move_right` out 1 each: at most one is high at a time.
- `fire` out 1: a one-frame pulse.
- `ai_state` out 2: current state, for debug and ILA.

## Operation
- Direction encoding is shared with the tank: up 0001, down 0010, left 0100, right 1000.
- States:
  - `SPAWN_WAIT` = 0
  - `CRUISE` = 1
  - `TURN` = 2
  - `PAUSE` = 3
- `SPAWN_WAIT`:
  - All outputs are 0.
  - `wait_cnt` (8 bits) counts down from `SPAWN_WAIT_FRAMES`.
  - When it reaches 0, go to `TURN`.
- `TURN` (exactly one frame; outputs 0):
  - New direction index `d` = `lfsr[1:0]` (0 up, 1 down, 2 left, 3 right).
  - Chase override: if `lfsr[3:2]`==0, head toward the player along the larger-magnitude axis of (player − tank). Ties go to the vertical axis.
  - If `turn_from_block` is set and `d` equals the current direction, use `d`+1 mod 4.
  - Load `run_cnt` (7 bits) with `MIN_RUN` + `lfsr[9:4]` (6 bits), then go to `CRUISE`.
- `CRUISE`:
  - Assert the `move_*` bit for the current direction.
  - Decrement `run_cnt` each frame.
  - If `blocked` is sampled high: set `turn_from_block`, go to `TURN`.
  - Else if `run_cnt` reaches 0: if `lfsr[10]`==1, go to `PAUSE`; otherwise go to `TURN` with `turn_from_block` cleared.
- `PAUSE`:
  - Movement outputs are 0.
  - `wait_cnt` counts down `PAUSE_FRAMES`, then go to `TURN`.
- Fire rule. `fire` is asserted for one frame when all of the following hold:
  - state is `CRUISE` or `PAUSE`;
  - `cool_cnt`==0;
  - `bullet_active`==0;
  - either line-of-sight holds, or `lfsr[15:12]`==0 (a 1/16 random chance).
- Line-of-sight:
  - Facing up or down: |`tank_x` − `player_x`| ≤ `ALIGN_TOL`, and the player is on the faced side (`player_y` < `tank_y` for up).
  - Facing left or right: the same test with the x and y axes swapped.
  - Differences are 11-bit signed values; take the absolute value before comparing.
- Cooldown: a fire pulse loads `cool_cnt` (7 bits) with `FIRE_COOLDOWN`. It then decrements each frame and saturates at 0.
- LFSR:
  - Sub-module `lfsr16`: Galois, taps x^16+x^14+x^13+x^11+1.
  - Steps every frame, regardless of state or `enable`.
  - Reset loads `LFSR_SEED`. A seed of 0 is replaced by 16'h0001.

## Timing
- All outputs are registered. A decision made from inputs sampled at edge N appears after edge N.
- `blocked` is combinational in the tank from `move_*`. A block detected at edge N removes `move_*` after edge N (`TURN` frame).
- Priority, highest first: `Reset_n`==0 > `got_hit` > `enable`==0 > normal operation.
- `Reset_n` low, sampled at an edge:
  - state = `SPAWN_WAIT`; `wait_cnt` = `SPAWN_WAIT_FRAMES`;
  - direction = `DIR_SPAWN`; `cool_cnt` = 0; `turn_from_block` = 0;
  - all outputs 0; `ai_state` = 0.
- `got_hit` high: same as reset, except the LFSR keeps running and `cool_cnt` is kept. This applies mid-cruise, mid-pause and mid-turn.
- `enable` low: state is forced to `SPAWN_WAIT` with `wait_cnt` reloaded. Outputs go to 0 after the next edge. Counters resume only once `enable` returns high.
- `fire` and `move_*` may be high in the same frame.
- `fire` is never high on two consecutive frames.
- `blocked` in the same frame that `run_cnt` hits 0: the block wins (`TURN` with `turn_from_block` set; no `PAUSE`).

## Structure
- Shared package `tank_pkg`:
  - `dir_t` one-hot constants `DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT`;
  - the `ai_state_t` enum;
  - the playfield limits `X_MIN`=80, `X_MAX`=528, `Y_MAX`=448.
- One sub-module, `lfsr16`: inputs clock, reset, seed; output `lfsr[15:0]`.
- Everything else lives in `enemy_tank_ctrl`.

## Test plan
- Reset: with `SPAWN_WAIT_FRAMES`=60, release `Reset_n` → outputs 0 for 60 frames, then one `TURN` frame, then exactly one `move_*` high. `ai_state` follows 0 → 2 → 1.
- Block turn: in `CRUISE` moving right, raise `blocked` for one frame → `move_right` drops on the next frame. The following `CRUISE` direction is not right.
- Line-of-sight fire: facing up, tank (200,300), player (205,100), `bullet_active`=0, `cool_cnt`=0 → `fire` pulses one frame. Holding the same conditions gives no further pulse for 45 frames.
- No fire with bullet up: hold `bullet_active`=1 for 200 frames with line-of-sight true → `fire` stays 0.
- Respawn mid-cruise: pulse `got_hit` at cruise frame 5 → outputs 0 next frame, direction = `DIR_SPAWN`, and 60 idle frames follow.
- Soak: 100k frames with random `blocked` and random positions → never more than one `move_*` high, never `fire` on consecutive frames, LFSR never 0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank definitions: one-hot directions, AI state encoding, playfield limits
// and small helpers used by the enemy-tank controller.
package tank_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_UP    = 4'b0001;
  localparam dir_t DIR_DOWN  = 4'b0010;
  localparam dir_t DIR_LEFT  = 4'b0100;
  localparam dir_t DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    SPAWN_WAIT = 2'd0,
    CRUISE     = 2'd1,
    TURN       = 2'd2,
    PAUSE      = 2'd3
  } ai_state_t;

  localparam int unsigned X_MIN = 80;
  localparam int unsigned X_MAX = 528;
  localparam int unsigned Y_MAX = 448;

  // Direction index 0..3 (up, down, left, right) to one-hot.
  function automatic dir_t idx_to_dir(input logic [1:0] idx);
    return dir_t'(4'b0001 << idx);
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

endpackage

// File: rtl/enemy_tank_ctrl_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), stepping once per frame.
module lfsr16 (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // NOTE: sequential state uses non-blocking assignments only; the combinational
  // next-state logic lives in always_comb with every output defaulted first.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) lfsr_q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else          lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/enemy_tank_ctrl.sv
// Autonomous enemy tank driver: random cruise/turn/pause movement with a
// line-of-sight fire rule; all outputs registered on frame_clk.
module enemy_tank_ctrl
  import tank_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter logic [3:0]  DIR_SPAWN         = 4'b0010,
  parameter int          SPAWN_WAIT_FRAMES = 60,
  parameter int          MIN_RUN           = 16,
  parameter int          PAUSE_FRAMES      = 8,
  parameter int          FIRE_COOLDOWN     = 45,
  parameter int          ALIGN_TOL         = 8
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic       blocked,
  input  logic       got_hit,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [3:0] tank_dir,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       bullet_active,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic [1:0] ai_state
);

  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .seed      (LFSR_SEED),
    .lfsr      (lfsr)
  );

  logic unused_lfsr_bit;
  assign unused_lfsr_bit = lfsr[11];

  ai_state_t   state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [6:0]  run_q, run_d;
  logic [6:0]  cool_q, cool_d;
  dir_t        dir_q, dir_d;
  logic        tfb_q, tfb_d;
  dir_t        move_q, move_d;
  logic        fire_q, fire_d;

  // Signed player-minus-tank offsets; positive dy means the player is below.
  logic signed [10:0] dx, dy;
  logic        [10:0] adx, ady;
  logic               x_aligned, y_aligned, los;

  assign dx  = $signed({1'b0, player_x}) - $signed({1'b0, tank_x});
  assign dy  = $signed({1'b0, player_y}) - $signed({1'b0, tank_y});
  assign adx = abs11(dx);
  assign ady = abs11(dy);
  assign x_aligned = (adx <= 11'(ALIGN_TOL));
  assign y_aligned = (ady <= 11'(ALIGN_TOL));

  always_comb begin
    los = 1'b0;
    case (tank_dir)
      DIR_UP:    los = x_aligned && (player_y < tank_y);
      DIR_DOWN:  los = x_aligned && (player_y > tank_y);
      DIR_LEFT:  los = y_aligned && (player_x < tank_x);
      DIR_RIGHT: los = y_aligned && (player_x > tank_x);
      default:   los = 1'b0;
    endcase
  end

  // New heading for a TURN frame: random, chase override, then block avoidance.
  logic [1:0] turn_idx;

  always_comb begin
    turn_idx = lfsr[1:0];
    if (lfsr[3:2] == 2'b00) begin
      if (adx > ady) turn_idx = dx[10] ? 2'd2 : 2'd3;
      else           turn_idx = dy[10] ? 2'd0 : 2'd1;
    end
    if (tfb_q && (idx_to_dir(turn_idx) == dir_q)) turn_idx = turn_idx + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    run_d   = run_q;
    cool_d  = cool_q;
    dir_d   = dir_q;
    tfb_d   = tfb_q;
    fire_d  = 1'b0;

    if (got_hit) begin
      state_d = SPAWN_WAIT;
      wait_d  = 8'(SPAWN_WAIT_FRAMES);
      dir_d   = DIR_SPAWN;
      tfb_d   = 1'b0;
    end else if (!enable) begin
      state_d = SPAWN_WAIT;
      wait_d  = 8'(SPAWN_WAIT_FRAMES);
    end else begin
      fire_d = ((state_q == CRUISE) || (state_q == PAUSE)) && (cool_q == 7'd0) &&
               !bullet_active && (los || (lfsr[15:12] == 4'h0));
      if (fire_d)              cool_d = 7'(FIRE_COOLDOWN);
      else if (cool_q != 7'd0) cool_d = cool_q - 7'd1;

      case (state_q)
        SPAWN_WAIT, PAUSE: begin
          if (wait_q <= 8'd1) state_d = TURN;
          else                wait_d  = wait_q - 8'd1;
        end
        TURN: begin
          dir_d   = idx_to_dir(turn_idx);
          run_d   = 7'(MIN_RUN) + 7'(lfsr[9:4]);
          state_d = CRUISE;
        end
        CRUISE: begin
          if (blocked) begin
            tfb_d   = 1'b1;
            state_d = TURN;
          end else if (run_q <= 7'd1) begin
            tfb_d = 1'b0;
            if (lfsr[10]) begin
              state_d = PAUSE;
              wait_d  = 8'(PAUSE_FRAMES);
            end else begin
              state_d = TURN;
            end
          end else begin
            run_d = run_q - 7'd1;
          end
        end
        default: state_d = SPAWN_WAIT;
      endcase
    end

    move_d = (state_d == CRUISE) ? dir_d : 4'b0000;
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q <= SPAWN_WAIT;
      wait_q  <= 8'(SPAWN_WAIT_FRAMES);
      run_q   <= 7'd0;
      cool_q  <= 7'd0;
      dir_q   <= DIR_SPAWN;
      tfb_q   <= 1'b0;
      move_q  <= 4'b0000;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
      cool_q  <= cool_d;
      dir_q   <= dir_d;
      tfb_q   <= tfb_d;
      move_q  <= move_d;
      fire_q  <= fire_d;
    end
  end

  assign move_up    = move_q[0];
  assign move_down  = move_q[1];
  assign move_left  = move_q[2];
  assign move_right = move_q[3];
  assign fire       = fire_q;
  assign ai_state   = state_q;

endmodule
